rng_share_arbiter: RTL and testbench

Shares a single Park-Miller random generator (seed' = seed*16807 mod 2^31-1) among NREQ requesters, such as the per-digit roll displays in the lab top level. Requests are served round-robin. Each grant advances the generator exactly one step through a multi-cycle multiply/fold sequence. The granted requester receives a one-cycle ack carrying a bit-slice of the new seed, so no two requesters ever receive the same sequence element.

---
 rtl/rng_pkg.sv | 20 ++
 rtl/pm_lcg_step.sv | 50 +++++
 rtl/rng_share_arbiter.sv | 110 +++++++++++
 tb/tb_rng_share_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the Park-Miller generator and its arbiter.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RED,
    ACK
  } state_t;

  localparam logic [14:0] LCG_A    = 15'd16807;
  localparam logic [30:0] LCG_M    = 31'h7FFF_FFFF;
  localparam logic [30:0] SEED_RST = 31'd1;

  // 0 and M are fixed points of the generator; replace them with the reset seed.
  function automatic logic [30:0] sanitize_seed(input logic [30:0] s);
    return ((s == '0) || (s == LCG_M)) ? SEED_RST : s;
  endfunction

endpackage

// File: rtl/pm_lcg_step.sv
// Two-stage registered Park-Miller step: capture seed, multiply, then fold mod 2^31-1.
module pm_lcg_step
  import rng_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_go,
  input  logic [30:0] i_seed,
  output logic [30:0] o_next,
  output logic        o_valid
);

  logic [30:0] seed_q;
  logic        go_q;
  logic [45:0] prod_q;
  logic        valid_q;
  logic [31:0] sum;

  // Stage 1: capture the seed to be advanced.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      seed_q <= '0;
      go_q   <= 1'b0;
    end else begin
      go_q <= i_go;
      if (i_go) seed_q <= i_seed;
    end
  end

  // Stage 2: register the full 46-bit product.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= go_q;
      if (go_q) prod_q <= 46'(seed_q) * 46'(LCG_A);
    end
  end

  // Fold the product mod 2^31-1: low 31 bits plus high bits, one conditional subtract.
  always_comb begin
    sum = {1'b0, prod_q[30:0]} + 32'(prod_q[45:31]);
    if (sum >= {1'b0, LCG_M}) sum = sum - {1'b0, LCG_M};
    o_next = sum[30:0];
  end

  assign o_valid = valid_q;

endmodule

// File: rtl/rng_share_arbiter.sv
// Round-robin sharing of one Park-Miller generator among NREQ requesters.
module rng_share_arbiter
  import rng_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int OUT_W     = 4,
  parameter int OUT_SHIFT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NREQ-1:0]  i_req,
  input  logic             i_seed_load,
  input  logic [30:0]      i_seed,
  output logic [NREQ-1:0]  o_ack,
  output logic [OUT_W-1:0] o_data,
  output logic             o_busy
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   pick;
  logic            any_req;
  logic            go;
  logic [30:0]     seed;
  logic [30:0]     lcg_next;
  logic            lcg_valid;

  pm_lcg_step u_step (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_go    (go),
    .i_seed  (seed),
    .o_next  (lcg_next),
    .o_valid (lcg_valid)
  );

  // Round-robin pick: first set request starting one past the last grant.
  always_comb begin
    pick    = ptr;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!any_req && i_req[idx]) begin
        pick    = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; a seed load in IDLE takes priority over requests.
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    case (state)
      IDLE: begin
        if (!i_seed_load && any_req) begin
          state_nx = MUL;
          go       = 1'b1;
        end
      end
      MUL:     state_nx = RED;
      RED:     state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Seed, grant bookkeeping and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      seed   <= SEED_RST;
      ptr    <= PW'(NREQ - 1);
      grant  <= '0;
      o_ack  <= '0;
      o_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_seed_load)  seed  <= sanitize_seed(i_seed);
          else if (any_req) grant <= pick;
        end
        RED: begin
          if (lcg_valid) begin
            seed   <= lcg_next;
            o_ack  <= NREQ'(1) << grant;
            o_data <= lcg_next[OUT_SHIFT +: OUT_W];
          end
        end
        ACK: begin
          o_ack <= '0;
          ptr   <= grant;
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Self-checking bench for rng_share_arbiter: directed scenarios plus randomized traffic.
module tb_rng_share_arbiter;

  localparam int NREQ      = 4;
  localparam int OUT_W     = 4;
  localparam int OUT_SHIFT = 4;
  localparam longint unsigned PM_M = 64'd2147483647;
  localparam longint unsigned PM_A = 64'd16807;

  logic             clk = 1'b0;
  logic             rst;
  logic [NREQ-1:0]  req;
  logic             seed_load;
  logic [30:0]      seed_in;
  logic [NREQ-1:0]  ack;
  logic [OUT_W-1:0] data;
  logic             busy;

  always #5 clk = ~clk;

  rng_share_arbiter #(
    .NREQ      (NREQ),
    .OUT_W     (OUT_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_seed_load (seed_load),
    .i_seed      (seed_in),
    .o_ack       (ack),
    .o_data      (data),
    .o_busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transaction-level view of the generator and its round-robin grants.
  longint unsigned  m_seed;
  int               m_ptr;
  int               m_grant;
  int               m_cycles_left;   // 0 = idle, otherwise cycles until the transaction retires
  logic [NREQ-1:0]  exp_ack;
  logic [OUT_W-1:0] exp_data;

  int               cyc;
  int               ack_idx_q[$];
  logic [OUT_W-1:0] data_q[$];
  int               ack_cyc_q[$];

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic longint unsigned clean_seed(input longint unsigned s);
    return (s == 0 || s == PM_M) ? 64'd1 : s;
  endfunction

  task automatic model_reset();
    m_seed        = 1;
    m_ptr         = NREQ - 1;
    m_grant       = 0;
    m_cycles_left = 0;
    exp_ack       = '0;
    exp_data      = '0;
  endtask

  // Called once per rising edge with the inputs that edge sampled.
  task automatic model_step();
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_cycles_left == 0) begin
      if (seed_load) begin
        m_seed = clean_seed(64'(seed_in));
      end else if (req != '0) begin
        m_grant       = rr_pick(req, m_ptr);
        m_cycles_left = 3;
      end
    end else begin
      m_cycles_left--;
      if (m_cycles_left == 1) begin
        m_seed   = (m_seed * PM_A) % PM_M;
        exp_ack  = NREQ'(1) << m_grant;
        exp_data = OUT_W'(m_seed >> OUT_SHIFT);
      end else if (m_cycles_left == 0) begin
        exp_ack = '0;
        m_ptr   = m_grant;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    check_eq("ack", 64'(ack), 64'(exp_ack));
    check_eq("busy", 64'(busy), 64'(m_cycles_left != 0));
    if (exp_ack != '0) check_eq("data", 64'(data), 64'(exp_data));
    if (ack != '0) begin
      for (int i = 0; i < NREQ; i++) if (ack[i]) ack_idx_q.push_back(i);
      data_q.push_back(data);
      ack_cyc_q.push_back(cyc);
    end
  endtask

  task automatic clear_logs();
    ack_idx_q.delete();
    data_q.delete();
    ack_cyc_q.delete();
    cyc = 0;
  endtask

  task automatic do_reset();
    req       = '0;
    seed_load = 1'b0;
    rst       = 1'b0;
    #1;
    model_reset();
    check_eq("rst_ack", 64'(ack), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_data", 64'(data), 64'(0));
    tick();
    tick();
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic run_until_acks(input int n, input int budget);
    int b;
    b = 0;
    while (data_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    check_eq("ack_count", 64'(data_q.size()), 64'(n));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int order_all[8];
    int order_odd[4];
    order_all = '{0, 1, 2, 3, 0, 1, 2, 3};
    order_odd = '{1, 3, 1, 3};
    req       = '0;
    seed_load = 1'b0;
    seed_in   = '0;
    rst       = 1'b0;
    cyc       = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single pulse from requester 0: ack on the third edge, data 0xA.
    req = 4'b0001;
    tick();
    req = '0;
    drain(5);
    check_eq("pulse_acks", 64'(data_q.size()), 64'(1));
    if (data_q.size() == 1) begin
      check_eq("pulse_data", 64'(data_q[0]), 64'(4'hA));
      check_eq("pulse_cyc", 64'(ack_cyc_q[0]), 64'(3));
      check_eq("pulse_idx", 64'(ack_idx_q[0]), 64'(0));
    end

    // Held request: A, F, D spaced 4 cycles apart.
    do_reset();
    req = 4'b0001;
    run_until_acks(3, 40);
    req = '0;
    drain(4);
    if (data_q.size() >= 3) begin
      check_eq("seq0", 64'(data_q[0]), 64'(4'hA));
      check_eq("seq1", 64'(data_q[1]), 64'(4'hF));
      check_eq("seq2", 64'(data_q[2]), 64'(4'hD));
      check_eq("gap01", 64'(ack_cyc_q[1] - ack_cyc_q[0]), 64'(4));
      check_eq("gap12", 64'(ack_cyc_q[2] - ack_cyc_q[1]), 64'(4));
    end

    // All four requesting: strict rotation.
    do_reset();
    req = 4'b1111;
    run_until_acks(8, 80);
    req = '0;
    drain(4);
    for (int i = 0; i < 8; i++)
      if (i < ack_idx_q.size()) check_eq($sformatf("rr_all%0d", i), 64'(ack_idx_q[i]), 64'(order_all[i]));

    do_reset();
    req = 4'b1010;
    run_until_acks(4, 40);
    req = '0;
    drain(4);
    for (int i = 0; i < 4; i++)
      if (i < ack_idx_q.size()) check_eq($sformatf("rr_odd%0d", i), 64'(ack_idx_q[i]), 64'(order_odd[i]));

    // Seed M-1 exercises the fold-subtract path: result 2147466840 = 0x7FFFBE58.
    do_reset();
    seed_in   = 31'h7FFF_FFFE;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req       = 4'b0001;
    tick();
    req = '0;
    drain(4);
    if (data_q.size() == 1) check_eq("fold_data", 64'(data_q[0]), 64'(4'h5));

    // Seed 0 loads as 1, so the next step yields 16807 again.
    clear_logs();
    seed_in   = '0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    req       = 4'b0100;
    tick();
    req = '0;
    drain(4);
    if (data_q.size() == 1) check_eq("zero_seed", 64'(data_q[0]), 64'(4'hA));

    // Load during MUL is ignored.
    do_reset();
    req = 4'b0001;
    tick();
    req       = '0;
    seed_in   = 31'd12345;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    drain(4);
    if (data_q.size() == 1) check_eq("busy_load", 64'(data_q[0]), 64'(4'hA));

    // Load and request together: load wins, request served next cycle (seed 2 -> 33614 = 0x834E).
    clear_logs();
    seed_in   = 31'd2;
    seed_load = 1'b1;
    req       = 4'b0010;
    tick();
    seed_load = 1'b0;
    tick();
    req = '0;
    drain(4);
    check_eq("ld_req_acks", 64'(data_q.size()), 64'(1));
    if (data_q.size() == 1) begin
      check_eq("ld_req_data", 64'(data_q[0]), 64'(4'h4));
      check_eq("ld_req_cyc", 64'(ack_cyc_q[0]), 64'(4));
    end

    // Reset asserted during RED: no ack, idle, seed back to 1.
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    rst = 1'b0;
    #2;
    model_reset();
    check_eq("midrst_ack", 64'(ack), 64'(0));
    check_eq("midrst_busy", 64'(busy), 64'(0));
    req = '0;
    tick();
    tick();
    rst = 1'b1;
    clear_logs();
    req = 4'b0001;
    tick();
    req = '0;
    drain(5);
    if (data_q.size() == 1) check_eq("midrst_data", 64'(data_q[0]), 64'(4'hA));
    else check_eq("midrst_acks", 64'(data_q.size()), 64'(1));

    // Randomized traffic with occasional loads, including the special seed values.
    for (int i = 0; i < 600; i++) begin
      req       = NREQ'($urandom);
      seed_load = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       seed_in = '0;
        1:       seed_in = 31'h7FFF_FFFF;
        2:       seed_in = 31'h7FFF_FFFE;
        default: seed_in = 31'($urandom);
      endcase
      tick();
    end
    req       = '0;
    seed_load = 1'b0;
    drain(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
